// File: rtl/mult_div_pkg.sv
// Shared types, constants and helpers for the multi-cycle signed multiply/divide unit.
package mult_div_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_COUNT = WIDTH;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MULT_RUN,
        DIV_RUN,
        DIV_FIX,
        FINISH
    } state_t;

    // The most negative value maps onto itself, which read unsigned is exactly its magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// Request/response bundle between the MIPS control unit (master) and the multiply/divide unit (slave).
interface mult_div_if;
    import mult_div_pkg::*;

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;

    modport master (
        output start, op, a_in, b_in,
        input  hi, lo, busy, done, div0
    );

    modport slave (
        input  start, op, a_in, b_in,
        output hi, lo, busy, done, div0
    );

endinterface

// File: rtl/mult_div_unit.sv
// Signed MULT/DIV responder: radix-2 Booth multiply and restoring divide on magnitudes, one bit per clock.
// Define MULT_DIV_DIV0_TRAP_EN to reject DIV by zero with a div0 strobe instead of running it.
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    mult_div_if.slave bus
);

    state_t             r_state, w_stateNext;
    logic [CNT_W-1:0]   r_count, w_countNext;
    logic [WIDTH-1:0]   r_a, w_aNext;
    logic [WIDTH-1:0]   r_b, w_bNext;
    logic [2*WIDTH:0]   r_acc, w_accNext;
    logic [WIDTH-1:0]   r_hi, w_hiNext;
    logic [WIDTH-1:0]   r_lo, w_loNext;
    logic               r_busy, w_busyNext;
    logic               r_done, w_doneNext;
    logic               w_accept;
`ifdef MULT_DIV_DIV0_TRAP_EN
    logic               r_div0, w_div0Next;
    logic               w_isDiv0;
`endif

    logic [WIDTH-1:0]   w_pHi;
    logic [WIDTH-1:0]   w_pLo;
    logic               w_qm1;
    logic [WIDTH:0]     w_boothSum;
    logic [WIDTH:0]     w_shRem;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;
    logic               w_lastIter;

    // The accumulator is {P_hi, P_lo, q-1} for MULT and {remainder, quotient, unused} for DIV.
    assign w_pHi      = r_acc[2*WIDTH:WIDTH+1];
    assign w_pLo      = r_acc[WIDTH:1];
    assign w_qm1      = r_acc[0];
    assign w_lastIter = (r_count == CNT_W'(ITER_COUNT - 1));

    // Booth add/subtract is done one bit wider so that a = most-negative cannot overflow P_hi.
    always_comb begin
        w_boothSum = {w_pHi[WIDTH-1], w_pHi};
        case ({w_pLo[0], w_qm1})
            2'b01:   w_boothSum = {w_pHi[WIDTH-1], w_pHi} + {r_a[WIDTH-1], r_a};
            2'b10:   w_boothSum = {w_pHi[WIDTH-1], w_pHi} - {r_a[WIDTH-1], r_a};
            default: w_boothSum = {w_pHi[WIDTH-1], w_pHi};
        endcase
    end

    assign w_shRem  = {w_pHi, w_pLo[WIDTH-1]};
    assign w_diff   = w_shRem - {1'b0, magnitude(r_b)};
    assign w_borrow = w_diff[WIDTH];

    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        w_aNext     = r_a;
        w_bNext     = r_b;
        w_accNext   = r_acc;
        w_hiNext    = r_hi;
        w_loNext    = r_lo;
        w_busyNext  = r_busy;
        w_doneNext  = 1'b0;
        w_accept    = 1'b0;
`ifdef MULT_DIV_DIV0_TRAP_EN
        w_div0Next  = 1'b0;
        w_isDiv0    = bus.start && (bus.op == OP_DIV) && (bus.b_in == '0);
`endif

        case (r_state)
            IDLE, FINISH: begin
                if (r_state == FINISH) begin
                    w_hiNext    = w_pHi;
                    w_loNext    = w_pLo;
                    w_doneNext  = 1'b1;
                    w_busyNext  = 1'b0;
                    w_stateNext = IDLE;
                end
`ifdef MULT_DIV_DIV0_TRAP_EN
                w_accept   = bus.start && !w_isDiv0;
                w_div0Next = w_isDiv0;
`else
                w_accept   = bus.start;
`endif
                // A request accepted in FINISH overlaps the done strobe for back-to-back issue.
                if (w_accept) begin
                    w_aNext     = bus.a_in;
                    w_bNext     = bus.b_in;
                    w_countNext = '0;
                    w_busyNext  = 1'b1;
                    case (bus.op)
                        OP_MULT: begin
                            w_accNext   = {{WIDTH{1'b0}}, bus.b_in, 1'b0};
                            w_stateNext = MULT_RUN;
                        end
                        OP_DIV: begin
                            w_accNext   = {{WIDTH{1'b0}}, magnitude(bus.a_in), 1'b0};
                            w_stateNext = DIV_RUN;
                        end
                        default: w_stateNext = IDLE;
                    endcase
                end
            end

            MULT_RUN: begin
                w_accNext   = {w_boothSum, w_pLo[WIDTH-1:1], w_pLo[0]};
                w_countNext = r_count + CNT_W'(1);
                if (w_lastIter) begin
                    w_stateNext = FINISH;
                end
            end

            DIV_RUN: begin
                w_accNext   = w_borrow ? {w_shRem[WIDTH-1:0], w_pLo[WIDTH-2:0], 1'b0, 1'b0}
                                       : {w_diff[WIDTH-1:0],  w_pLo[WIDTH-2:0], 1'b1, 1'b0};
                w_countNext = r_count + CNT_W'(1);
                if (w_lastIter) begin
                    w_stateNext = DIV_FIX;
                end
            end

            // Remainder follows the dividend's sign, quotient the XOR of both: truncation toward zero.
            DIV_FIX: begin
                w_accNext   = {(r_a[WIDTH-1] ? -w_pHi : w_pHi),
                               ((r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_pLo : w_pLo),
                               1'b0};
                w_stateNext = FINISH;
            end

            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MULT_DIV_DIV0_TRAP_EN
            r_div0  <= 1'b0;
`endif
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
            r_a     <= w_aNext;
            r_b     <= w_bNext;
            r_acc   <= w_accNext;
            r_hi    <= w_hiNext;
            r_lo    <= w_loNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
`ifdef MULT_DIV_DIV0_TRAP_EN
            r_div0  <= w_div0Next;
`endif
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
`ifdef MULT_DIV_DIV0_TRAP_EN
    assign bus.div0 = r_div0;
`else
    assign bus.div0 = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written timing sequences, random ops vs. arithmetic model.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vector_t;

    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   errorCount = 0;

    mult_div_if bus();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Holds start for exactly one edge (edge 0), then scrambles operands to prove they were latched.
    task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic runAndCheck(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expected);
        int edges;
        applyStimulus(op, a, b);
        checkOutput({name, " busy"}, 64'(bus.busy), 64'd1);
        waitDone(edges);
        checkOutput({name, " latency"}, 64'(edges), (op == OP_MULT) ? 64'd33 : 64'd34);
        checkOutput({name, " result"}, {bus.hi, bus.lo}, expected);
        checkOutput({name, " busy at done"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        checkOutput({name, " done strobe"}, 64'(bus.done), 64'd0);
    endtask

    // MIPS semantics straight from the arithmetic: signed product, truncating division, defined corner cases.
    function automatic logic [63:0] modelResult(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa = a;
        sb = b;
        if (op == OP_MULT) begin
            return 64'(longint'(sa) * longint'(sb));
        end
        if (b == 32'd0) begin
            return {a, (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
        end
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            return {32'h0, 32'h8000_0000};
        end
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t     vectors[$];
        int          edges;
        logic        rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        logic        sawDone;
        logic        sawBusy;

        vectors.push_back('{"mult 7x-3",      OP_MULT, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        vectors.push_back('{"mult maxpos^2",  OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001});
        vectors.push_back('{"mult minneg^2",  OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        vectors.push_back('{"mult -1x-1",     OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
        vectors.push_back('{"div -7/2",       OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vectors.push_back('{"div overflow",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        vectors.push_back('{"div 7/-2",       OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
        vectors.push_back('{"div -7/-2",      OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003});
        vectors.push_back('{"div 5/7",        OP_DIV,  32'd5,         32'd7,         32'h0000_0005, 32'h0000_0000});

        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a_in  = '0;
        bus.b_in  = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        checkOutput("reset flags", 64'({bus.busy, bus.done, bus.div0}), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vectors.size(); i++) begin
            runAndCheck(vectors[i].name, vectors[i].op, vectors[i].a, vectors[i].b,
                        {vectors[i].expHi, vectors[i].expLo});
        end

        // Second start at edge 5 must be ignored while the first MULT is in flight.
        applyStimulus(OP_MULT, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a_in  = 32'd1000;
        bus.b_in  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(edges);
        checkOutput("overlap latency", 64'(edges), 64'd28);
        checkOutput("overlap result", {bus.hi, bus.lo}, 64'd42);
        @(posedge clk);
        #1;

        applyStimulus(OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midop reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        checkOutput("midop reset flags", 64'({bus.busy, bus.done, bus.div0}), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        runAndCheck("mult 3x4", OP_MULT, 32'd3, 32'd4, 64'd12);

`ifdef MULT_DIV_DIV0_TRAP_EN
        applyStimulus(OP_DIV, 32'd100, 32'd0);
        checkOutput("div0 strobe", 64'(bus.div0), 64'd1);
        checkOutput("div0 busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("div0 strobe width", 64'(bus.div0), 64'd0);
        sawDone = 1'b0;
        sawBusy = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            sawDone |= bus.done;
            sawBusy |= bus.busy;
        end
        checkOutput("div0 no done", 64'(sawDone), 64'd0);
        checkOutput("div0 no busy", 64'(sawBusy), 64'd0);
        checkOutput("div0 hi/lo held", {bus.hi, bus.lo}, 64'd12);
`else
        applyStimulus(OP_DIV, 32'd100, 32'd0);
        checkOutput("div by 0 no trap", 64'(bus.div0), 64'd0);
        waitDone(edges);
        checkOutput("div by 0 latency", 64'(edges), 64'd34);
        checkOutput("div by 0 result", {bus.hi, bus.lo}, {32'd100, 32'hFFFF_FFFF});
        sawDone = 1'b0;
        sawBusy = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            sawDone |= bus.done;
            sawBusy |= bus.busy;
        end
        checkOutput("hold after done", 64'({sawDone, sawBusy}), 64'd0);
        checkOutput("hi/lo held", {bus.hi, bus.lo}, {32'd100, 32'hFFFF_FFFF});
`endif

        // New start sampled on the edge that ends FINISH; done and busy overlap for one cycle.
        applyStimulus(OP_MULT, 32'd5, 32'd6);
        repeat (32) @(posedge clk);
        #1;
        checkOutput("b2b no early done", 64'(bus.done), 64'd0);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a_in  = 32'd50;
        bus.b_in  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("b2b first done", 64'(bus.done), 64'd1);
        checkOutput("b2b first result", {bus.hi, bus.lo}, 64'd30);
        checkOutput("b2b second busy", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        waitDone(edges);
        checkOutput("b2b second latency", 64'(edges + 1), 64'd34);
        checkOutput("b2b second result", {bus.hi, bus.lo}, {32'd1, 32'd7});
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            rOp = 1'($urandom_range(0, 1));
            rA  = $urandom;
            rB  = $urandom;
            if ($urandom_range(0, 2) == 0) rA = 32'($urandom_range(0, 40)) - 32'd20;
            if ($urandom_range(0, 2) == 0) rB = 32'($urandom_range(0, 40)) - 32'd20;
            if ($urandom_range(0, 7) == 0) rA = 32'h8000_0000;
`ifdef MULT_DIV_DIV0_TRAP_EN
            if (rOp == OP_DIV && rB == 32'd0) rB = 32'd1;
`else
            if (rOp == OP_DIV && $urandom_range(0, 9) == 0) rB = 32'd0;
`endif
            applyStimulus(rOp, rA, rB);
            waitDone(edges);
            checkOutput($sformatf("rand %0d latency", i), 64'(edges), (rOp == OP_MULT) ? 64'd33 : 64'd34);
            checkOutput($sformatf("rand %0d %s 0x%0h 0x%0h", i, (rOp == OP_MULT) ? "mult" : "div", rA, rB),
                        {bus.hi, bus.lo}, modelResult(rOp, rA, rB));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
